meas_chal_load: RTL and testbench
=================================

# meas_chal_load

Challenge loader for the PUF measurement path. It accepts a byte stream of oscillator-selector pairs over a valid/ready handshake and writes the pairs into the challenge memory, starting at `C_MEMSTADDR`. It is the write side of the memory that the measurement engine later reads pair by pair. It optionally range-checks every pair and signals completion once `C_OIDWIDTH` pairs have been stored.

## Interface
Parameters:
- `C_IOSCNUM`, 48: number of ring oscillators; a legal selector is in the range 0 to `C_IOSCNUM`-1.
- `C_OIDWIDTH`, 24: number of pairs to load (one pair per ID bit).
- `C_MEMDATAWIDTH`, 8: selector and byte width.
- `C_MEMADDRWIDTH`, 24: memory address width.
- `C_MEMSTADDR`, 0: address of the first selector.

Ports:
- `I_sclk`  in  1: system clock; all logic on its rising edge.
- `I_rst`  in  1: reset, asynchronous, active-high.
- `I_clr`  in  1: synchronous restart of the load sequence.
- `I_data`  in  `C_MEMDATAWIDTH`: selector byte.
- `I_valid`  in  1: `I_data` is valid.
- `O_ready`  out  1: block accepts a byte this cycle.
- `O_mem_we`  out  1: one-cycle memory write strobe.
- `O_mem_addr`  out  `C_MEMADDRWIDTH`: write address.
- `O_mem_data`  out  `C_MEMDATAWIDTH`: write data.
- `O_done`  out  1: all pairs written; stays high until restart.
- `O_err`  out  1: sticky; at least one illegal pair was seen.
- `O_err_pair`  out  `$clog2(C_OIDWIDTH)`: index of the first illegal pair.

## Operation
- States:
  - `ST_SEL1`: expecting the first selector of a pair.
  - `ST_SEL2`: expecting the second selector of a pair.
  - `ST_DONE`: all pairs loaded.
- Accept: a byte is taken when `I_valid` and `O_ready` are both high.
- Transitions:
  - `ST_SEL1` + accept → `ST_SEL2`; the byte is latched as sel1.
  - `ST_SEL2` + accept → pair counter +1; go to `ST_DONE` if the count reaches `C_OIDWIDTH`, else `ST_SEL1`.
  - `ST_DONE` holds until `I_clr` or `I_rst`.
- Every accepted byte is written unchanged, in stream order, so sel1 lands at an even offset and sel2 at an odd offset from `C_MEMSTADDR`.
- Internal next-address counter:
  - starts at `C_MEMSTADDR` and increments after each write;
  - wraps modulo 2^`C_MEMADDRWIDTH`; the wrap is not an error.
- Pair counter width is `$clog2(C_OIDWIDTH+1)`.
- Illegal pair: sel1 ≥ `C_IOSCNUM`, or sel2 ≥ `C_IOSCNUM`, or sel1 == sel2.
  - The pair is still written.
  - `O_err` is set and stays set.
  - `O_err_pair` captures the pair index on the first error only.
- `I_clr`:
  - returns the block to `ST_SEL1`;
  - resets the next-address counter to `C_MEMSTADDR`;
  - clears the pair count, `O_done`, `O_err` and `O_err_pair`;
  - has priority over a simultaneous accept, so that byte is dropped.
- Memory already written before a restart is not erased.

## Timing
- Reset values:
  - `O_ready` = 0
  - `O_mem_we` = 0
  - `O_mem_addr` = `C_MEMSTADDR`
  - `O_mem_data` = 0
  - `O_done` = 0
  - `O_err` = 0
  - `O_err_pair` = 0
  - state = `ST_SEL1`
- `O_ready` is registered:
  - It is 1 from the first clock edge after `I_rst` is released, while the state is not `ST_DONE`.
  - It drops to 0 in the cycle after the final accept.
  - It is 0 in the cycle after `I_clr`, and back to 1 one cycle later.
- Byte accepted in cycle N → in cycle N+1, `O_mem_we` = 1 with `O_mem_addr`/`O_mem_data` set for that byte.
- `O_mem_addr` and `O_mem_data` hold their values while `O_mem_we` = 0.
- Back-to-back accepts are supported at one byte per cycle; gaps in `I_valid` are allowed without limit.
- `O_err` and `O_err_pair` update in cycle N+1 after the sel2 accept.
- `O_done` rises in the same cycle as the final `O_mem_we`.
- `I_rst` asserted mid-load: all outputs return immediately to their reset values, and the partial load is abandoned.

## Configuration
- `MEAS_CHAL_CHECK_EN` defined: the pair checker is compiled in; `O_err` and `O_err_pair` behave as described above.
- Not defined: no checker logic; `O_err` and `O_err_pair` are tied to 0; all other behaviour is identical.

## Structure
- Shared package `meas_pkg` holds:
  - the state enum (`ST_SEL1`, `ST_SEL2`, `ST_DONE`);
  - localparams for the pair-count width and error-index width.
- Sub-module `meas_chal_chk`: combinational legality check (sel1, sel2 → illegal). It is instantiated only under `MEAS_CHAL_CHECK_EN`.

## Test plan
- Streaming load: after reset, stream 48 bytes 0..47 with `I_valid` held high → 48 writes to addresses 0..47 with data = address; `O_done` = 1 with the 48th write; `O_ready` = 0 afterwards; `O_err` = 0.
- Gapped load: `I_valid` toggles every other cycle, pairs (3,7) ×24 → writes alternate 3,7; `O_done` after 24 pairs; no missing or duplicated writes.
- Illegal pairs: pair 5 = (48,2) and pair 9 = (4,4) → both pairs are written; `O_err` = 1 from pair 5; `O_err_pair` = 5 and is unchanged after pair 9. Without the macro, `O_err` stays 0.
- Clear collision: `I_clr` pulsed while a byte is valid after 10 bytes → that byte is not written; the next accepted byte goes to `C_MEMSTADDR`; `O_err` is cleared.
- Mid-load reset and wrap: `I_rst` after 20 bytes → outputs return to reset values immediately. Separately, with `C_MEMSTADDR` = 2^24-2 → the third write goes to address 0.

Source files
------------

// File: rtl/meas_pkg.sv
// Shared types and width helpers for the challenge loader.
package meas_pkg;

    typedef enum logic [1:0] {
        ST_SEL1 = 2'd0,
        ST_SEL2 = 2'd1,
        ST_DONE = 2'd2
    } meas_state_t;

    localparam int unsigned MEAS_OIDWIDTH_DFLT = 24;

    // Pair counter must be able to hold the full pair count.
    function automatic int unsigned pcnt_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

    // Error index only needs to address pairs 0..n-1 (at least one bit).
    function automatic int unsigned eidx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned MEAS_PCNT_W = pcnt_width(MEAS_OIDWIDTH_DFLT);
    localparam int unsigned MEAS_EIDX_W = eidx_width(MEAS_OIDWIDTH_DFLT);

endpackage

// File: rtl/meas_chal_chk.sv
// Combinational legality check for one oscillator-selector pair.
module meas_chal_chk #(
    parameter int unsigned C_IOSCNUM      = 48,
    parameter int unsigned C_MEMDATAWIDTH = 8
) (
    input  logic [C_MEMDATAWIDTH-1:0] I_sel1,
    input  logic [C_MEMDATAWIDTH-1:0] I_sel2,
    output logic                      O_illegal
);

    // One extra bit so an oscillator count of 2^width still compares correctly.
    localparam logic [C_MEMDATAWIDTH:0] LP_NUM = (C_MEMDATAWIDTH + 1)'(C_IOSCNUM);

    // Out-of-range selector or a ring compared against itself.
    always_comb begin
        O_illegal = 1'b0;
        if (({1'b0, I_sel1} >= LP_NUM) || ({1'b0, I_sel2} >= LP_NUM) || (I_sel1 == I_sel2)) begin
            O_illegal = 1'b1;
        end
    end

endmodule

// File: rtl/meas_chal_load.sv
// Challenge loader: streams selector bytes into challenge memory, two per pair.
// Optional pair checker compiled in with the MEAS_CHAL_CHECK_EN macro.
module meas_chal_load
    import meas_pkg::*;
#(
    parameter int unsigned C_IOSCNUM      = 48,
    parameter int unsigned C_OIDWIDTH     = MEAS_OIDWIDTH_DFLT,
    parameter int unsigned C_MEMDATAWIDTH = 8,
    parameter int unsigned C_MEMADDRWIDTH = 24,
    parameter int unsigned C_MEMSTADDR    = 0
) (
    input  logic                               I_sclk,
    input  logic                               I_rst,
    input  logic                               I_clr,
    input  logic [C_MEMDATAWIDTH-1:0]          I_data,
    input  logic                               I_valid,
    output logic                               O_ready,
    output logic                               O_mem_we,
    output logic [C_MEMADDRWIDTH-1:0]          O_mem_addr,
    output logic [C_MEMDATAWIDTH-1:0]          O_mem_data,
    output logic                               O_done,
    output logic                               O_err,
    output logic [eidx_width(C_OIDWIDTH)-1:0]  O_err_pair
);

    localparam int unsigned LP_PCW = pcnt_width(C_OIDWIDTH);
    localparam int unsigned LP_EIW = eidx_width(C_OIDWIDTH);
    localparam logic [C_MEMADDRWIDTH-1:0] LP_STADDR = C_MEMADDRWIDTH'(C_MEMSTADDR);
    localparam logic [LP_PCW-1:0] LP_NPAIRS = LP_PCW'(C_OIDWIDTH);

    meas_state_t                r_state;
    meas_state_t                w_state_nxt;
    logic                       r_ready;
    logic                       r_we;
    logic                       r_done;
    logic [C_MEMADDRWIDTH-1:0]  r_addr;
    logic [C_MEMADDRWIDTH-1:0]  r_next_addr;
    logic [C_MEMDATAWIDTH-1:0]  r_data;
    logic [LP_PCW-1:0]          r_pair_cnt;
    logic [LP_PCW-1:0]          w_pair_cnt_inc;
    logic                       w_accept;
    logic                       w_last;

    assign w_accept       = I_valid & r_ready;
    assign w_pair_cnt_inc = r_pair_cnt + LP_PCW'(1);
    assign w_last         = (r_state == ST_SEL2) && (w_pair_cnt_inc == LP_NPAIRS);

    // State register.
    always_ff @(posedge I_sclk or posedge I_rst) begin
        if (I_rst) begin
            r_state <= ST_SEL1;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: clear wins over a simultaneous accept.
    always_comb begin
        w_state_nxt = r_state;
        if (I_clr) begin
            w_state_nxt = ST_SEL1;
        end else if (w_accept) begin
            case (r_state)
                ST_SEL1: w_state_nxt = ST_SEL2;
                ST_SEL2: w_state_nxt = w_last ? ST_DONE : ST_SEL1;
                default: w_state_nxt = r_state;
            endcase
        end
    end

    // Handshake, write port, address/pair counters and completion flag.
    always_ff @(posedge I_sclk or posedge I_rst) begin
        if (I_rst) begin
            r_ready     <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= LP_STADDR;
            r_next_addr <= LP_STADDR;
            r_data      <= '0;
            r_pair_cnt  <= '0;
            r_done      <= 1'b0;
        end else begin
            // Ready is registered, so it lags a clear by one cycle.
            r_ready <= !I_clr && (w_state_nxt != ST_DONE);
            r_we    <= w_accept && !I_clr;
            if (I_clr) begin
                r_next_addr <= LP_STADDR;
                r_pair_cnt  <= '0;
                r_done      <= 1'b0;
            end else if (w_accept) begin
                r_addr      <= r_next_addr;
                r_next_addr <= r_next_addr + C_MEMADDRWIDTH'(1);
                r_data      <= I_data;
                if (r_state == ST_SEL2) begin
                    r_pair_cnt <= w_pair_cnt_inc;
                end
                if (w_last) begin
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign O_ready    = r_ready;
    assign O_mem_we   = r_we;
    assign O_mem_addr = r_addr;
    assign O_mem_data = r_data;
    assign O_done     = r_done;

`ifdef MEAS_CHAL_CHECK_EN
    logic [C_MEMDATAWIDTH-1:0] r_sel1;
    logic                      w_illegal;
    logic                      r_err;
    logic [LP_EIW-1:0]         r_err_pair;

    meas_chal_chk #(
        .C_IOSCNUM      (C_IOSCNUM),
        .C_MEMDATAWIDTH (C_MEMDATAWIDTH)
    ) u_chk (
        .I_sel1    (r_sel1),
        .I_sel2    (I_data),
        .O_illegal (w_illegal)
    );

    // Latch sel1; record only the first illegal pair until restart.
    always_ff @(posedge I_sclk or posedge I_rst) begin
        if (I_rst) begin
            r_sel1     <= '0;
            r_err      <= 1'b0;
            r_err_pair <= '0;
        end else if (I_clr) begin
            r_err      <= 1'b0;
            r_err_pair <= '0;
        end else if (w_accept) begin
            if (r_state == ST_SEL1) begin
                r_sel1 <= I_data;
            end
            if ((r_state == ST_SEL2) && w_illegal && !r_err) begin
                r_err      <= 1'b1;
                r_err_pair <= LP_EIW'(r_pair_cnt);
            end
        end
    end

    assign O_err      = r_err;
    assign O_err_pair = r_err_pair;
`else
    logic w_unused_cfg;
    assign w_unused_cfg = (C_IOSCNUM != 0);
    assign O_err        = 1'b0;
    assign O_err_pair   = '0;
`endif

endmodule

// File: tb/tb_meas_chal_load.sv
// Scoreboard bench for meas_chal_load with a pair-level reference model.
`timescale 1ns/1ps
module tb_meas_chal_load;

    localparam int unsigned NPAIRS  = 24;
    localparam int unsigned NBYTES  = 2 * NPAIRS;
    localparam int unsigned NOSC    = 48;
    localparam int unsigned WRAP_ST = 32'd16777214;
`ifdef MEAS_CHAL_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        I_sclk  = 1'b0;
    logic        I_rst   = 1'b1;
    logic        I_clr   = 1'b0;
    logic        I_valid = 1'b0;
    logic [7:0]  I_data  = 8'h00;
    logic        O_ready, O_mem_we, O_done, O_err;
    logic [23:0] O_mem_addr;
    logic [7:0]  O_mem_data;
    logic [4:0]  O_err_pair;

    logic        w_clr   = 1'b0;
    logic        w_valid = 1'b0;
    logic [7:0]  w_data  = 8'h00;
    logic        w_ready, w_we, w_done, w_err;
    logic [23:0] w_addr;
    logic [7:0]  w_mdata;
    logic [4:0]  w_err_pair;

    meas_chal_load dut (
        .I_sclk     (I_sclk),
        .I_rst      (I_rst),
        .I_clr      (I_clr),
        .I_data     (I_data),
        .I_valid    (I_valid),
        .O_ready    (O_ready),
        .O_mem_we   (O_mem_we),
        .O_mem_addr (O_mem_addr),
        .O_mem_data (O_mem_data),
        .O_done     (O_done),
        .O_err      (O_err),
        .O_err_pair (O_err_pair)
    );

    meas_chal_load #(
        .C_MEMSTADDR (WRAP_ST)
    ) dut_wrap (
        .I_sclk     (I_sclk),
        .I_rst      (I_rst),
        .I_clr      (w_clr),
        .I_data     (w_data),
        .I_valid    (w_valid),
        .O_ready    (w_ready),
        .O_mem_we   (w_we),
        .O_mem_addr (w_addr),
        .O_mem_data (w_mdata),
        .O_done     (w_done),
        .O_err      (w_err),
        .O_err_pair (w_err_pair)
    );

    always #5 I_sclk = ~I_sclk;

    typedef struct {
        logic [23:0] addr;
        logic [7:0]  data;
        logic        done;
        logic        err;
        logic [4:0]  epair;
    } exp_t;

    exp_t       q[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         m_cnt    = 0;
    logic [7:0] m_sel1   = 8'h00;
    logic       m_err    = 1'b0;
    logic [4:0] m_epair  = 5'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        m_cnt   = 0;
        m_err   = 1'b0;
        m_epair = 5'd0;
    endtask

    // Byte k of a load lands at start+k; odd bytes close a pair and are judged.
    task automatic model_accept(input logic [7:0] b);
        exp_t e;
        if (m_cnt % 2 == 0) begin
            m_sel1 = b;
        end else if (CHK && !m_err &&
                     (int'(m_sel1) >= int'(NOSC) || int'(b) >= int'(NOSC) || m_sel1 == b)) begin
            m_err   = 1'b1;
            m_epair = 5'(m_cnt / 2);
        end
        e.addr  = 24'(m_cnt);
        e.data  = b;
        e.done  = (m_cnt + 1 == int'(NBYTES));
        e.err   = m_err;
        e.epair = m_epair;
        q.push_back(e);
        m_cnt++;
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        int waited;
        waited  = 0;
        I_valid = 1'b0;
        repeat (gap) begin
            @(posedge I_sclk);
            #1;
        end
        I_valid = 1'b1;
        I_data  = b;
        forever begin
            @(negedge I_sclk);
            if (O_ready === 1'b1) begin
                model_accept(b);
                @(posedge I_sclk);
                #1;
                break;
            end
            @(posedge I_sclk);
            #1;
            waited++;
            if (waited > 20) begin
                n_checks++;
                n_fail++;
                $display("FAIL send_timeout: byte 0x%0h not accepted within 20 cycles", b);
                break;
            end
        end
        I_valid = 1'b0;
    endtask

    task automatic do_clear();
        I_clr = 1'b1;
        @(posedge I_sclk);
        #1;
        I_clr = 1'b0;
        model_clear();
        chk("clr_ready_low", O_ready, 0);
        chk("clr_done", O_done, 0);
        chk("clr_err", O_err, 0);
        @(posedge I_sclk);
        #1;
        chk("clr_ready_back", O_ready, 1);
    endtask

    // Monitor: every write strobe must match the oldest expected write.
    initial begin
        exp_t e;
        forever begin
            @(negedge I_sclk);
            if (O_mem_we === 1'b1) begin
                if (q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, none expected",
                             O_mem_addr, O_mem_data);
                end else begin
                    e = q.pop_front();
                    chk("wr_addr", O_mem_addr, e.addr);
                    chk("wr_data", O_mem_data, e.data);
                    chk("wr_done", O_done, e.done);
                    chk("wr_err", O_err, e.err);
                    chk("wr_err_pair", O_err_pair, e.epair);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] s1, s2;
        int         waited;

        // Reset values.
        repeat (2) @(posedge I_sclk);
        #1;
        chk("rst_ready", O_ready, 0);
        chk("rst_we", O_mem_we, 0);
        chk("rst_addr", O_mem_addr, 0);
        chk("rst_data", O_mem_data, 0);
        chk("rst_done", O_done, 0);
        chk("rst_err", O_err, 0);
        chk("rst_err_pair", O_err_pair, 0);
        chk("rst_wrap_addr", w_addr, WRAP_ST);
        I_rst = 1'b0;
        #1;
        chk("rel_ready_still_low", O_ready, 0);
        @(posedge I_sclk);
        #1;
        chk("rel_ready_high", O_ready, 1);

        // Address wrap on the second instance.
        chk("wrap_ready", w_ready, 1);
        w_valid = 1'b1;
        w_data  = 8'h11;
        @(posedge I_sclk);
        #1;
        chk("wrap_we0", w_we, 1);
        chk("wrap_addr0", w_addr, 24'hFFFFFE);
        chk("wrap_data0", w_mdata, 8'h11);
        w_data = 8'h22;
        @(posedge I_sclk);
        #1;
        chk("wrap_addr1", w_addr, 24'hFFFFFF);
        w_data = 8'h33;
        @(posedge I_sclk);
        #1;
        chk("wrap_addr2", w_addr, 24'h000000);
        chk("wrap_data2", w_mdata, 8'h33);
        w_valid = 1'b0;

        // Streaming load 0..47 back to back.
        for (int i = 0; i < int'(NBYTES); i++) send(8'(i), 0);
        chk("stream_ready_after", O_ready, 0);
        chk("stream_done", O_done, 1);
        chk("stream_err", O_err, 0);
        I_valid = 1'b1;
        repeat (4) begin
            @(posedge I_sclk);
            #1;
        end
        chk("done_ready_holds_low", O_ready, 0);
        chk("done_holds", O_done, 1);
        I_valid = 1'b0;

        // Gapped load of (3,7) pairs.
        do_clear();
        for (int i = 0; i < int'(NBYTES); i++) send((i % 2 == 0) ? 8'd3 : 8'd7, 1);
        chk("gap_done", O_done, 1);
        chk("gap_ready_after", O_ready, 0);

        // Random pairs with illegal pairs 5 and 9; random bytes after pair 11.
        do_clear();
        for (int p = 0; p < int'(NPAIRS); p++) begin
            if (p == 5) begin
                s1 = 8'd48;
                s2 = 8'd2;
            end else if (p == 9) begin
                s1 = 8'd4;
                s2 = 8'd4;
            end else if (p < 12) begin
                s1 = 8'($urandom_range(0, 47));
                s2 = 8'((int'(s1) + 1 + int'($urandom_range(0, 46))) % 48);
            end else begin
                s1 = 8'($urandom_range(0, 63));
                s2 = 8'($urandom_range(0, 63));
            end
            send(s1, int'($urandom_range(0, 2)));
            send(s2, int'($urandom_range(0, 2)));
        end
        chk("illegal_err", O_err, 32'(CHK));
        chk("illegal_err_pair", O_err_pair, CHK ? 32'd5 : 32'd0);
        chk("illegal_done", O_done, 1);

        // Clear colliding with a valid byte.
        do_clear();
        send(8'd50, 0);
        send(8'd3, 0);
        for (int i = 2; i < 10; i++) send(8'($urandom_range(0, 47)), int'($urandom_range(0, 1)));
        chk("pre_clr_err", O_err, 32'(CHK));
        I_valid = 1'b1;
        I_data  = 8'hAA;
        I_clr   = 1'b1;
        @(posedge I_sclk);
        #1;
        I_clr   = 1'b0;
        I_valid = 1'b0;
        model_clear();
        chk("coll_no_write", O_mem_we, 0);
        chk("coll_err_cleared", O_err, 0);
        chk("coll_ready_low", O_ready, 0);
        @(posedge I_sclk);
        #1;
        chk("coll_ready_back", O_ready, 1);
        for (int i = 0; i < 4; i++) send(8'($urandom_range(0, 47)), 0);

        // Mid-load reset after 20 bytes.
        do_clear();
        for (int i = 0; i < 20; i++) send(8'($urandom_range(1, 47)), 0);
        chk("mid_we_before_rst", O_mem_we, 1);
        chk("mid_pending", 32'(q.size()), 1);
        I_rst = 1'b1;
        #1;
        chk("mid_rst_we", O_mem_we, 0);
        chk("mid_rst_addr", O_mem_addr, 0);
        chk("mid_rst_data", O_mem_data, 0);
        chk("mid_rst_ready", O_ready, 0);
        chk("mid_rst_done", O_done, 0);
        chk("mid_rst_err", O_err, 0);
        q.delete();
        model_clear();
        @(posedge I_sclk);
        #1;
        I_rst = 1'b0;
        @(posedge I_sclk);
        #1;
        chk("mid_rel_ready", O_ready, 1);
        for (int i = 0; i < 6; i++) send(8'($urandom_range(0, 47)), int'($urandom_range(0, 2)));

        waited = 0;
        while (q.size() != 0 && waited < 10) begin
            @(posedge I_sclk);
            waited++;
        end
        @(posedge I_sclk);
        #1;
        chk("queue_drained", 32'(q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
